execute_iterative: RTL and testbench
====================================

# execute_iterative

Parametrised execute stage for the Flurbie core pipeline, sitting between the read and write stages. Single-cycle ALU operations complete in one clock. Multiply and divide run on an iterative shift-add / restoring datapath that stalls the read stage until done, and divide yields quotient and remainder from the same pass. The block carries a valid/hold handshake on both sides.

## Interface
Parameters:
- WIDTH, 32, operand/result width (≥8)
- REG_BITS, 5, destination register index width

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream operation present
- in_hold  out  1  upstream must hold current operation
- in_flush  in  1  abort in-flight work (synchronous)
- in_operation  in  4  opcode
- in_left, in_right  in  WIDTH  operands (right already adjusted)
- in_carry  in  1  carry flag for opcodes 1/3
- in_destination  in  REG_BITS  destination register
- out_hold  in  1  downstream stall
- out_valid  out  1  result present
- out_destination  out  REG_BITS  destination register
- out_value  out  WIDTH  result
- out_remainder  out  WIDTH  divide remainder (see Configuration)
- out_flags  out  4  {C,N,V,Z}
- busy  out  1  state ≠ IDLE

## Operation
- Opcodes: 0 add; 1 add+C; 2 sub; 3 sub−C; 4 signed mul; 5 unsigned mul; 6 signed div; 7 unsigned div; 8 and; 9 nand; 10 or; 11 nor; 12 xor; 13 xnor; 14 pass left; 15 pass right, C = (left == right).
- States: IDLE, MUL, DIV, FIXUP, WAIT.
- IDLE, in_valid, !out_hold:
  - opcodes 0–3 and 8–15 register the result directly.
  - 4/5 load the multiplier and counter = WIDTH, then go to MUL.
  - 6/7 with right ≠ 0 load operand magnitudes (signed: absolute values) and counter = WIDTH, then go to DIV.
- Divide by zero is single-cycle: value = all ones, remainder = left, V = 1.
- MUL: one shift-add step per cycle. Result is the low WIDTH product bits, so signed and unsigned give the same bits.
- DIV: one restoring step per cycle, then FIXUP.
- FIXUP (opcode 6):
  - Negate the quotient when operand signs differ.
  - The remainder takes the sign of the dividend.
  - For min ÷ −1 the result is quotient = min, remainder = 0, V = 0.
- After the last MUL step or FIXUP: write the result and go to IDLE if !out_hold, else go to WAIT. WAIT writes once out_hold falls.
- in_hold = out_hold | (state ≠ IDLE).
- Flags:
  - N = value msb; Z = (value == 0).
  - C = carry-out for add and borrow-out for sub; C is 0 for all other opcodes except 15.
  - V = signed overflow for 0–3 only, plus divide by zero.
- While out_hold is high, all outputs are frozen.
- When no result is written at an edge with !out_hold, out_valid ← 0.
- in_flush:
  - Next edge: state ← IDLE and out_valid ← 0.
  - Flush overrides out_hold and a simultaneous in_valid; the flushed operation is dropped.
- Reset: state IDLE, out_valid 0, out_destination 0, out_value 0, out_remainder 0, out_flags 0, busy 0.

## Timing
- Single-cycle ops: the result is visible after the edge that samples in_valid (latency 1).
- Multiply: accept edge, then WIDTH MUL edges. out_valid rises after edge WIDTH+1 from acceptance.
- Divide (6/7): WIDTH DIV edges plus one FIXUP edge, for latency WIDTH+2. Divide by zero has latency 1.
- During a multi-cycle op out_valid is 0 from the edge after acceptance until the result edge.
- Back-to-back single-cycle ops sustain one result per clock.
- Each WAIT cycle adds one cycle of latency.
- Reset assertion mid-operation clears state immediately and asynchronously. The in-flight result is discarded.

## Configuration
- EXECUTE_REMAINDER_EN defined: out_remainder carries the divide remainder on opcodes 6/7 and is 0 for other opcodes.
- Undefined: out_remainder is tied to 0, and the remainder register and its FIXUP logic are omitted. Quotient behaviour and latency are unchanged.

## Test plan
- Add 0x7FFFFFFF + 1 (op 0) → value 0x80000000, flags C0 N1 V1 Z0, one cycle later.
- Sub 5 − 5 (op 2) back-to-back with xor 0xF0F0 ^ 0x0FF0 → consecutive results 0 (C0 N0 V0 Z1) and 0xFF00.
- Signed mul −3 × 7 (op 4) → value 0xFFFFFFEB, out_valid after 33 edges, in_hold high throughout.
- Signed div −7 ÷ 2 (op 6) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF (macro on) or 0 (macro off), latency 34. Also 7 ÷ 0 (op 7) → 0xFFFFFFFF, V1, latency 1.
- Raise out_hold on the final DIV step for 3 cycles → unit sits in WAIT, result appears the edge after release with outputs stable beforehand.
- Assert in_flush mid-multiply, then reset_n low mid-divide → busy 0 and out_valid 0 in both cases, and the next add completes normally.

Source files
------------

// File: rtl/execute_iterative.sv
// Flurbie execute stage: single-cycle ALU plus iterative shift-add multiply and restoring divide.
// Define EXECUTE_REMAINDER_EN to drive the divide remainder on out_remainder (otherwise tied to 0).
module execute_iterative #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_hold,
  input  logic                in_flush,
  input  logic [3:0]          in_operation,
  input  logic [WIDTH-1:0]    in_left,
  input  logic [WIDTH-1:0]    in_right,
  input  logic                in_carry,
  input  logic [REG_BITS-1:0] in_destination,
  input  logic                out_hold,
  output logic                out_valid,
  output logic [REG_BITS-1:0] out_destination,
  output logic [WIDTH-1:0]    out_value,
  output logic [WIDTH-1:0]    out_remainder,
  output logic [3:0]          out_flags,
  output logic                busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_WAIT} state_t;
  state_t r_state, w_state_nx;

  // mul: multiplicand / multiplier / product; div: dividend->quotient / divisor / partial remainder
  logic [WIDTH-1:0]    r_a, r_b, r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_negq;
  logic [REG_BITS-1:0] r_dest;
  logic                r_valid;
  logic [REG_BITS-1:0] r_odest;
  logic [WIDTH-1:0]    r_oval;
  logic [3:0]          r_oflags;

  logic             w_accept, w_div0, w_single, w_last, w_wr, w_c, w_v, w_s_c, w_s_v;
  logic [WIDTH:0]   w_sum, w_trial;
  logic [WIDTH-1:0] w_s_val, w_s_rem, w_val, w_rem, w_mul_sum, w_div_acc, w_div_a;
  logic [WIDTH-1:0] w_fx_q, w_fx_r, w_lmag, w_rmag;

  assign w_div0   = (in_operation[3:1] == 3'b011) && (in_right == '0);
  assign w_single = (in_operation[3:2] != 2'b01) || w_div0;
  assign w_accept = (r_state == S_IDLE) && in_valid && !out_hold && !in_flush;
  assign w_last   = (r_cnt == CW'(1));
  assign in_hold  = out_hold | (r_state != S_IDLE);
  assign busy     = (r_state != S_IDLE);

  assign w_lmag = (in_operation == 4'd6 && in_left[WIDTH-1])  ? '0 - in_left  : in_left;
  assign w_rmag = (in_operation == 4'd6 && in_right[WIDTH-1]) ? '0 - in_right : in_right;

  assign w_mul_sum = r_acc + (r_b[0] ? r_a : '0);
  // Trial subtract on the shifted partial remainder; a negative result restores.
  assign w_trial   = {r_acc, r_a[WIDTH-1]} - {1'b0, r_b};
  assign w_div_acc = w_trial[WIDTH] ? {r_acc[WIDTH-2:0], r_a[WIDTH-1]} : w_trial[WIDTH-1:0];
  assign w_div_a   = {r_a[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_fx_q    = r_negq ? '0 - r_a : r_a;

`ifdef EXECUTE_REMAINDER_EN
  logic r_negr;
  logic [WIDTH-1:0] r_orem;
  assign w_fx_r        = r_negr ? '0 - r_acc : r_acc;
  assign out_remainder = r_orem;
`else
  assign w_fx_r        = '0;
  assign out_remainder = '0;
`endif

  always_comb begin
    w_sum   = '0;
    w_s_val = '0;
    w_s_rem = '0;
    w_s_c   = 1'b0;
    w_s_v   = 1'b0;
    case (in_operation)
      4'd0, 4'd1: begin
        w_sum = {1'b0, in_left} + {1'b0, in_right} + {{WIDTH{1'b0}}, in_operation[0] & in_carry};
        w_s_v = (in_left[WIDTH-1] == in_right[WIDTH-1]) && (w_sum[WIDTH-1] != in_left[WIDTH-1]);
      end
      4'd2, 4'd3: begin
        w_sum = {1'b0, in_left} - {1'b0, in_right} - {{WIDTH{1'b0}}, in_operation[0] & in_carry};
        w_s_v = (in_left[WIDTH-1] != in_right[WIDTH-1]) && (w_sum[WIDTH-1] != in_left[WIDTH-1]);
      end
      4'd6, 4'd7: begin
        w_s_val = '1;
        w_s_rem = in_left;
        w_s_v   = 1'b1;
      end
      4'd8:  w_s_val = in_left & in_right;
      4'd9:  w_s_val = ~(in_left & in_right);
      4'd10: w_s_val = in_left | in_right;
      4'd11: w_s_val = ~(in_left | in_right);
      4'd12: w_s_val = in_left ^ in_right;
      4'd13: w_s_val = ~(in_left ^ in_right);
      4'd14: w_s_val = in_left;
      4'd15: begin
        w_s_val = in_right;
        w_s_c   = (in_left == in_right);
      end
      default: ;
    endcase
    if (in_operation[3:2] == 2'b00) begin
      w_s_val = w_sum[WIDTH-1:0];
      w_s_c   = w_sum[WIDTH];
    end
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;

  always_comb begin
    w_state_nx = r_state;
    w_wr       = 1'b0;
    w_val      = '0;
    w_rem      = '0;
    w_c        = 1'b0;
    w_v        = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_single) begin
          w_wr  = 1'b1;
          w_val = w_s_val;
          w_rem = w_s_rem;
          w_c   = w_s_c;
          w_v   = w_s_v;
        end else w_state_nx = in_operation[1] ? S_DIV : S_MUL;
      end
      S_MUL: if (w_last) begin
        w_val = w_mul_sum;
        if (out_hold) w_state_nx = S_WAIT;
        else begin w_wr = 1'b1; w_state_nx = S_IDLE; end
      end
      S_DIV: if (w_last) w_state_nx = S_FIXUP;
      S_FIXUP: begin
        w_val = w_fx_q;
        w_rem = w_fx_r;
        if (out_hold) w_state_nx = S_WAIT;
        else begin w_wr = 1'b1; w_state_nx = S_IDLE; end
      end
      S_WAIT: begin
        w_val = r_a;
        w_rem = r_acc;
        if (!out_hold) begin w_wr = 1'b1; w_state_nx = S_IDLE; end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (in_flush) begin
      w_state_nx = S_IDLE;
      w_wr       = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_negq <= 1'b0;
      r_dest <= '0;
`ifdef EXECUTE_REMAINDER_EN
      r_negr <= 1'b0;
`endif
    end else begin
      if (w_accept && !w_single) begin
        r_a    <= in_operation[1] ? w_lmag : in_left;
        r_b    <= in_operation[1] ? w_rmag : in_right;
        r_acc  <= '0;
        r_cnt  <= CW'(WIDTH);
        r_negq <= (in_operation == 4'd6) && (in_left[WIDTH-1] ^ in_right[WIDTH-1]);
        r_dest <= in_destination;
`ifdef EXECUTE_REMAINDER_EN
        r_negr <= (in_operation == 4'd6) && in_left[WIDTH-1];
`endif
      end else if (r_state == S_MUL) begin
        r_acc <= w_mul_sum;
        r_a   <= {r_a[WIDTH-2:0], 1'b0};
        r_b   <= {1'b0, r_b[WIDTH-1:1]};
        r_cnt <= r_cnt - CW'(1);
      end else if (r_state == S_DIV) begin
        r_acc <= w_div_acc;
        r_a   <= w_div_a;
        r_cnt <= r_cnt - CW'(1);
      end
      // Park the finished result so WAIT can release it later.
      if (w_state_nx == S_WAIT && r_state != S_WAIT) begin
        r_a   <= w_val;
        r_acc <= w_rem;
      end
    end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_odest  <= '0;
      r_oval   <= '0;
      r_oflags <= '0;
`ifdef EXECUTE_REMAINDER_EN
      r_orem   <= '0;
`endif
    end else if (in_flush) begin
      r_valid <= 1'b0;
    end else if (!out_hold) begin
      r_valid <= w_wr;
      if (w_wr) begin
        r_odest  <= (r_state == S_IDLE) ? in_destination : r_dest;
        r_oval   <= w_val;
        r_oflags <= {w_c, w_val[WIDTH-1], w_v, (w_val == '0)};
`ifdef EXECUTE_REMAINDER_EN
        r_orem   <= w_rem;
`endif
      end
    end

  assign out_valid       = r_valid;
  assign out_destination = r_odest;
  assign out_value       = r_oval;
  assign out_flags       = r_oflags;
endmodule

// File: tb/tb_execute_iterative.sv
// Scoreboard bench for execute_iterative: directed plan cases plus randomized ops with random downstream stalls.
module tb_execute_iterative;
  localparam int W = 32;

  logic         clock = 1'b0, reset_n = 1'b0, in_valid = 1'b0, in_flush = 1'b0;
  logic         in_carry = 1'b0, out_hold = 1'b0;
  logic         in_hold, out_valid, busy;
  logic [3:0]   in_operation = '0, out_flags;
  logic [W-1:0] in_left = '0, in_right = '0, out_value, out_remainder;
  logic [4:0]   in_destination = '0, out_destination;

  execute_iterative #(.WIDTH(W), .REG_BITS(5)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_hold(in_hold),
    .in_flush(in_flush), .in_operation(in_operation), .in_left(in_left),
    .in_right(in_right), .in_carry(in_carry), .in_destination(in_destination),
    .out_hold(out_hold), .out_valid(out_valid), .out_destination(out_destination),
    .out_value(out_value), .out_remainder(out_remainder), .out_flags(out_flags),
    .busy(busy));

  always #5 clock = ~clock;

  typedef struct {
    string        name;
    logic [4:0]   dst;
    logic [W-1:0] val;
    logic [W-1:0] rem;
    logic [3:0]   flg;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0, cyc = 0;
  bit   rnd_hold = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference: plain wide arithmetic on the architectural rules.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] l, r, input logic c);
    exp_t   e;
    longint ul, ur, sl, sr, s, ss, b;
    int     il, ir;
    logic   cf, vf;
    ul = longint'(l);  ur = longint'(r);
    sl = longint'($signed(l));  sr = longint'($signed(r));
    cf = 1'b0;  vf = 1'b0;  e.rem = '0;  e.val = '0;
    case (op)
      4'd0, 4'd1: begin
        b = (op == 4'd1) ? longint'(c) : 64'd0;
        s = ul + ur + b;  e.val = s[31:0];  cf = s[32];
        ss = sl + sr + b;  vf = (ss != longint'($signed(e.val)));
      end
      4'd2, 4'd3: begin
        b = (op == 4'd3) ? longint'(c) : 64'd0;
        s = ul - ur - b;  e.val = s[31:0];  cf = (ul < ur + b);
        ss = sl - sr - b;  vf = (ss != longint'($signed(e.val)));
      end
      4'd4, 4'd5: begin
        s = (op == 4'd4) ? sl * sr : ul * ur;
        e.val = s[31:0];
      end
      4'd6: begin
        il = $signed(l);  ir = $signed(r);
        if (r == '0) begin e.val = '1; e.rem = l; vf = 1'b1; end
        else if (l == 32'h8000_0000 && r == 32'hffff_ffff) begin e.val = l; e.rem = '0; end
        else begin e.val = 32'(il / ir); e.rem = 32'(il % ir); end
      end
      4'd7: begin
        if (r == '0) begin e.val = '1; e.rem = l; vf = 1'b1; end
        else begin e.val = l / r; e.rem = l % r; end
      end
      4'd8:  e.val = l & r;
      4'd9:  e.val = ~(l & r);
      4'd10: e.val = l | r;
      4'd11: e.val = ~(l | r);
      4'd12: e.val = l ^ r;
      4'd13: e.val = ~(l ^ r);
      4'd14: e.val = l;
      default: begin e.val = r; cf = (l == r); end
    endcase
`ifndef EXECUTE_REMAINDER_EN
    e.rem = '0;
`endif
    e.flg = {cf, e.val[W-1], vf, (e.val == '0)};
    e.cyc = 0;
    e.dst = '0;
    e.name = "";
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Present an op from a negedge, wait for acceptance, queue its expected result.
  task automatic issue(input string nm, input logic [3:0] op, input logic [W-1:0] l, r,
                       input logic c, input int lat);
    exp_t e;
    int   n;
    e = model(op, l, r, c);
    e.name = nm;
    e.dst  = 5'($urandom_range(0, 31));
    in_operation = op;  in_left = l;  in_right = r;  in_carry = c;
    in_destination = e.dst;  in_valid = 1'b1;
    if (rnd_hold) out_hold = ($urandom_range(0, 3) == 0);
    #1;
    n = 0;
    while (in_hold) begin
      @(negedge clock);
      if (rnd_hold) out_hold = ($urandom_range(0, 3) == 0);
      #1;
      n++;
      if (n > 400) begin
        n_tests++;  n_fail++;
        $display("FAIL %s accept timeout: in_hold %b want 0", nm, in_hold);
        in_valid = 1'b0;
        return;
      end
    end
    e.cyc = (lat > 0) ? cyc + lat : 0;
    exp_q.push_back(e);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("drain pending results", 64'(exp_q.size()), 64'(0));
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hffff_ffff;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  bit   mon_h;
  exp_t mon_e;
  always @(posedge clock) begin
    mon_h = out_hold;
    #1;
    if (reset_n && !mon_h && out_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result: unexpected output val=%h dst=%0d", out_value, out_destination);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_value !== mon_e.val || out_remainder !== mon_e.rem || out_flags !== mon_e.flg ||
            out_destination !== mon_e.dst || (mon_e.cyc != 0 && cyc != mon_e.cyc)) begin
          n_fail++;
          $display("FAIL result %s: got dst=%0d val=%h rem=%h flags=%b cyc=%0d, want dst=%0d val=%h rem=%h flags=%b cyc=%0d",
                   mon_e.name, out_destination, out_value, out_remainder, out_flags, cyc,
                   mon_e.dst, mon_e.val, mon_e.rem, mon_e.flg, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           hl, vl, bad;
    logic [W-1:0] held;
    repeat (2) @(negedge clock);
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset out_destination", 64'(out_destination), 64'(0));
    chk("reset out_value", 64'(out_value), 64'(0));
    chk("reset out_remainder", 64'(out_remainder), 64'(0));
    chk("reset out_flags", 64'(out_flags), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    reset_n = 1'b1;
    @(negedge clock);

    issue("add_ovf", 4'd0, 32'h7fff_ffff, 32'd1, 1'b0, 1);
    issue("sub_eq", 4'd2, 32'd5, 32'd5, 1'b0, 1);
    issue("xor", 4'd12, 32'h0000_f0f0, 32'h0000_0ff0, 1'b0, 1);
    issue("addc_wrap", 4'd1, 32'hffff_ffff, 32'd0, 1'b1, 1);
    issue("subc_borrow", 4'd3, 32'd0, 32'd0, 1'b1, 1);
    issue("pass_r_eq", 4'd15, 32'd9, 32'd9, 1'b0, 1);
    issue("nor", 4'd11, 32'h1234_0000, 32'h0000_5678, 1'b0, 1);
    drain();

    issue("mul_s", 4'd4, 32'hffff_fffd, 32'd7, 1'b0, 33);
    hl = 0;  vl = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (!in_hold) hl++;
      if (out_valid) vl++;
      @(negedge clock);
    end
    chk("mul in_hold low cycles", 64'(hl), 64'(0));
    chk("mul out_valid high cycles", 64'(vl), 64'(0));
    drain();

    issue("div_s", 4'd6, 32'hffff_fff9, 32'd2, 1'b0, 34);
    drain();
    issue("div0", 4'd7, 32'd7, 32'd0, 1'b0, 1);
    issue("div_min", 4'd6, 32'h8000_0000, 32'hffff_ffff, 1'b0, 34);
    drain();
    issue("div_u", 4'd7, 32'hffff_fff0, 32'd7, 1'b0, 34);
    drain();

    // Stall across the last DIV step, FIXUP and one WAIT cycle.
    issue("div_wait", 4'd7, 32'd1000, 32'd7, 1'b0, 36);
    repeat (31) @(negedge clock);
    held = out_value;
    out_hold = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      #1;
      if (out_value !== held || out_valid) bad++;
    end
    chk("wait busy", 64'(busy), 64'(1));
    chk("wait outputs stable", 64'(bad), 64'(0));
    out_hold = 1'b0;
    drain();

    issue("mul_flush", 4'd5, 32'd123, 32'd456, 1'b0, 33);
    repeat (10) @(negedge clock);
    exp_q.delete();
    in_flush = 1'b1;
    @(negedge clock);
    in_flush = 1'b0;
    #1;
    chk("flush busy", 64'(busy), 64'(0));
    chk("flush out_valid", 64'(out_valid), 64'(0));
    @(negedge clock);
    issue("add_after_flush", 4'd0, 32'd10, 32'd20, 1'b0, 1);
    drain();

    // Flush wins over out_hold and a simultaneous valid op.
    in_operation = 4'd0;  in_left = 32'd1;  in_right = 32'd2;
    in_valid = 1'b1;  in_flush = 1'b1;  out_hold = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;  in_flush = 1'b0;  out_hold = 1'b0;
    #1;
    chk("flush+valid out_valid", 64'(out_valid), 64'(0));
    chk("flush+valid busy", 64'(busy), 64'(0));
    @(negedge clock);

    issue("div_reset", 4'd6, 32'h1234_5678, 32'd3, 1'b0, 34);
    repeat (10) @(negedge clock);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("reset mid-div busy", 64'(busy), 64'(0));
    chk("reset mid-div out_valid", 64'(out_valid), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    issue("add_after_reset", 4'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1);
    drain();

    rnd_hold = 1'b1;
    for (int k = 0; k < 200; k++)
      issue("rand", 4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(),
            1'($urandom_range(0, 1)), 0);
    rnd_hold = 1'b0;
    out_hold = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
